cu_gen2: RTL and testbench
==========================

CU_GEN2 -- requirements
Module: cu_gen2

Interface
REQ-001 Parameter PC_W, default 16: program-counter / return-address width.
REQ-002 Parameter RS_DEPTH, default 4: return-stack entries (power of two, 2..16).
REQ-003 Parameter MEM_WAIT_EN, default 1: when 1, memory states wait on mem_ready; when 0, mem_ready is ignored (treated as 1).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 IR  in  16  instruction register; opcode IR[15:9], W IR[8:6], R IR[5:3], S IR[2:0].
REQ-007 N, Z, C  in  1 each  datapath ALU status.
REQ-008 mem_ready  in  1  memory access complete this cycle.
REQ-009 pc_in  in  PC_W  current PC (already incremented past CALL).
REQ-010 W_Adr, R_Adr, S_Adr  out  3 each  register-file addresses.
REQ-011 adr_sel, s_sel, pc_inc, ir_ld, mw_en, rw_en  out  1 each  control word as in the existing CU.
REQ-012 pc_ld  out  1; pc_sel  out  2  (00 ALU/branch, 01 memory, 10 ret_pc).
REQ-013 alu_op  out  4  ALU opcode.
REQ-014 mem_req  out  1  memory access requested.
REQ-015 ret_pc  out  PC_W  top of return stack.
REQ-016 status  out  8  {ps_N,ps_Z,ps_C,state[4:0]}; FF in RESET, F0 in ILLEGAL_OP, E0 in STACK_FAULT.

Function
REQ-017 States: RESET, FETCH, DECODE, ADD, SUB, CMP, MOV, SHL, SHR, INC, DEC, LD, STO, LDI, HALT, JE, JNE, JC, JMP, CALL, RET, JN, ILLEGAL_OP, STACK_FAULT.
REQ-018 Opcodes 70h-7Fh decode exactly as the existing CU; 60h CALL, 61h RET, 62h JN; all others -> ILLEGAL_OP.
REQ-019 RESET -> FETCH unconditionally; FETCH -> DECODE; DECODE -> execute state; every execute state -> FETCH, except HALT, ILLEGAL_OP, STACK_FAULT (self-loop until reset).
REQ-020 FETCH, LD, STO, LDI assert mem_req and hold state with all write strobes (ir_ld, pc_inc, rw_en, mw_en, pc_ld) low until mem_ready=1; strobes pulse only in the mem_ready cycle.
REQ-021 Flag register {ps_N,ps_Z,ps_C} loads {N,Z,C} in the completing cycle of ADD, SUB, CMP, SHL, SHR, INC, DEC, LDI, JMP; holds otherwise; cleared in HALT, ILLEGAL_OP, STACK_FAULT.
REQ-022 JE/JNE/JC/JN: pc_ld = ps_Z / ~ps_Z / ps_C / ps_N, pc_sel=00, one cycle.
REQ-023 CALL: push pc_in, pc_ld=1, pc_sel=00 (branch target), one cycle.
REQ-024 RET: pc_ld=1, pc_sel=10, pop, one cycle; ret_pc valid combinationally from top entry.
REQ-025 Stack count 0..RS_DEPTH; CALL when full or RET when empty -> STACK_FAULT, no push/pop, pc_ld=0.
REQ-026 Stack pointer arithmetic modulo RS_DEPTH; count never wraps.
REQ-027 Control outputs are combinational from state, IR, ps flags, mem_ready; no output depends on N/Z/C except next-flag logic.
REQ-028 Unused addresses drive 000; ret_pc drives 0 when stack empty.

Reset
REQ-029 reset=1 at any clock edge, including mid-wait in a memory state, forces state=RESET, flags=000, stack count=0 on that edge; outputs then show RESET control word (all strobes 0, status FFh).
REQ-030 Stack storage contents need not be cleared.

Structure
REQ-031 Shared package cu_pkg holds state encoding (5-bit), opcode constants, pc_sel encodings, and status codes.
REQ-032 Return stack is sub-module cu_ret_stack (params PC_W, RS_DEPTH; push, pop, din, top, full, empty).

Verification
REQ-033 Reset, IR=E000h (ADD R0,R0,R0), mem_ready=1 -> RESET, FETCH, DECODE, ADD; rw_en=1 in ADD; status FFh, 80h, C0h.
REQ-034 FETCH with mem_ready low 3 cycles -> mem_req=1, ir_ld=0 for 3 cycles, ir_ld=pc_inc=1 on 4th.
REQ-035 CALL with pc_in=0123h, then RET -> ret_pc=0123h, pc_sel=10, pc_ld=1 in RET; count back to 0.
REQ-036 RS_DEPTH+1 consecutive CALLs -> STACK_FAULT on last, status E0h, held until reset.
REQ-037 SUB setting N=1, then JN -> pc_ld=1; then CMP with N=0, JN -> pc_ld=0.
REQ-038 reset asserted during LD wait -> next cycle state RESET, rw_en=0, count=0.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the gen2 control unit: state encoding, opcodes,
// pc_sel encodings, ALU opcodes, status codes and the opcode decoder.
package cu_pkg;

    localparam int unsigned STATE_W = 5;
    localparam int unsigned OP_W    = 7;

    // FSM state encoding
    localparam logic [4:0] S_RESET       = 5'd0;
    localparam logic [4:0] S_FETCH       = 5'd1;
    localparam logic [4:0] S_DECODE      = 5'd2;
    localparam logic [4:0] S_ADD         = 5'd3;
    localparam logic [4:0] S_SUB         = 5'd4;
    localparam logic [4:0] S_CMP         = 5'd5;
    localparam logic [4:0] S_MOV         = 5'd6;
    localparam logic [4:0] S_SHL         = 5'd7;
    localparam logic [4:0] S_SHR         = 5'd8;
    localparam logic [4:0] S_INC         = 5'd9;
    localparam logic [4:0] S_DEC         = 5'd10;
    localparam logic [4:0] S_LD          = 5'd11;
    localparam logic [4:0] S_STO         = 5'd12;
    localparam logic [4:0] S_LDI         = 5'd13;
    localparam logic [4:0] S_HALT        = 5'd14;
    localparam logic [4:0] S_JE          = 5'd15;
    localparam logic [4:0] S_JNE         = 5'd16;
    localparam logic [4:0] S_JC          = 5'd17;
    localparam logic [4:0] S_JMP         = 5'd18;
    localparam logic [4:0] S_CALL        = 5'd19;
    localparam logic [4:0] S_RET         = 5'd20;
    localparam logic [4:0] S_JN          = 5'd21;
    localparam logic [4:0] S_ILLEGAL_OP  = 5'd22;
    localparam logic [4:0] S_STACK_FAULT = 5'd23;

    // Opcodes (IR[15:9])
    localparam logic [6:0] OP_ADD  = 7'h70;
    localparam logic [6:0] OP_SUB  = 7'h71;
    localparam logic [6:0] OP_CMP  = 7'h72;
    localparam logic [6:0] OP_MOV  = 7'h73;
    localparam logic [6:0] OP_SHL  = 7'h74;
    localparam logic [6:0] OP_SHR  = 7'h75;
    localparam logic [6:0] OP_INC  = 7'h76;
    localparam logic [6:0] OP_DEC  = 7'h77;
    localparam logic [6:0] OP_LD   = 7'h78;
    localparam logic [6:0] OP_STO  = 7'h79;
    localparam logic [6:0] OP_LDI  = 7'h7A;
    localparam logic [6:0] OP_HALT = 7'h7B;
    localparam logic [6:0] OP_JE   = 7'h7C;
    localparam logic [6:0] OP_JNE  = 7'h7D;
    localparam logic [6:0] OP_JC   = 7'h7E;
    localparam logic [6:0] OP_JMP  = 7'h7F;
    localparam logic [6:0] OP_CALL = 7'h60;
    localparam logic [6:0] OP_RET  = 7'h61;
    localparam logic [6:0] OP_JN   = 7'h62;

    // PC source select
    localparam logic [1:0] PCSEL_ALU = 2'b00;
    localparam logic [1:0] PCSEL_MEM = 2'b01;
    localparam logic [1:0] PCSEL_RET = 2'b10;

    // ALU opcodes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_PASS = 4'd2;
    localparam logic [3:0] ALU_SHL  = 4'd3;
    localparam logic [3:0] ALU_SHR  = 4'd4;
    localparam logic [3:0] ALU_INC  = 4'd5;
    localparam logic [3:0] ALU_DEC  = 4'd6;

    // Fixed status codes; other states report {flags, state}
    localparam logic [7:0] STAT_RESET  = 8'hFF;
    localparam logic [7:0] STAT_FETCH  = 8'h80;
    localparam logic [7:0] STAT_DECODE = 8'hC0;
    localparam logic [7:0] STAT_ILL    = 8'hF0;
    localparam logic [7:0] STAT_SFAULT = 8'hE0;

    // Opcode to execute-state map; unknown opcodes trap
    function automatic logic [4:0] decode_op(input logic [6:0] op);
        logic [4:0] s;
        case (op)
            OP_ADD:  s = S_ADD;
            OP_SUB:  s = S_SUB;
            OP_CMP:  s = S_CMP;
            OP_MOV:  s = S_MOV;
            OP_SHL:  s = S_SHL;
            OP_SHR:  s = S_SHR;
            OP_INC:  s = S_INC;
            OP_DEC:  s = S_DEC;
            OP_LD:   s = S_LD;
            OP_STO:  s = S_STO;
            OP_LDI:  s = S_LDI;
            OP_HALT: s = S_HALT;
            OP_JE:   s = S_JE;
            OP_JNE:  s = S_JNE;
            OP_JC:   s = S_JC;
            OP_JMP:  s = S_JMP;
            OP_CALL: s = S_CALL;
            OP_RET:  s = S_RET;
            OP_JN:   s = S_JN;
            default: s = S_ILLEGAL_OP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cu_ret_stack.sv
// Return-address stack for CALL/RET.
// Ports: clk, reset (sync, active-high), push/pop requests, din (address to
// push), top (top entry, 0 when empty), full, empty.
module cu_ret_stack #(
    parameter int unsigned PC_W     = 16,
    parameter int unsigned RS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] top,
    output logic            full,
    output logic            empty
);

    localparam int unsigned PTR_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RS_DEPTH + 1);

    logic [PC_W-1:0]  mem [RS_DEPTH];
    logic [PTR_W-1:0] sp;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] top_idx;

    assign full    = (count == CNT_W'(RS_DEPTH));
    assign empty   = (count == '0);
    // sp points at the next free slot; wraps naturally since depth is 2^n
    assign top_idx = sp - PTR_W'(1);
    assign top     = empty ? '0 : mem[top_idx];

    // Pointer and occupancy; count saturates by refusing over/underflow
    always_ff @(posedge clk) begin
        if (reset) begin
            sp    <= '0;
            count <= '0;
        end else if (push && !full) begin
            sp    <= sp + PTR_W'(1);
            count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            sp    <= sp - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

    // Storage is not reset
    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            mem[sp] <= din;
        end
    end

endmodule

// File: rtl/cu_gen2.sv
// Gen2 control unit: fetch/decode/execute FSM with memory wait states,
// flag register, conditional branches and a return stack for CALL/RET.
// Ports: clk, reset (sync, active-high), IR, N/Z/C status, mem_ready, pc_in;
// outputs register-file addresses, control strobes, pc_sel, alu_op, mem_req,
// ret_pc (top of return stack) and status.
module cu_gen2
    import cu_pkg::*;
#(
    parameter int unsigned PC_W        = 16,
    parameter int unsigned RS_DEPTH    = 4,
    parameter bit          MEM_WAIT_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     IR,
    input  logic            N,
    input  logic            Z,
    input  logic            C,
    input  logic            mem_ready,
    input  logic [PC_W-1:0] pc_in,
    output logic [2:0]      W_Adr,
    output logic [2:0]      R_Adr,
    output logic [2:0]      S_Adr,
    output logic            adr_sel,
    output logic            s_sel,
    output logic            pc_inc,
    output logic            ir_ld,
    output logic            mw_en,
    output logic            rw_en,
    output logic            pc_ld,
    output logic [1:0]      pc_sel,
    output logic [3:0]      alu_op,
    output logic            mem_req,
    output logic [PC_W-1:0] ret_pc,
    output logic [7:0]      status
);

    logic [4:0] state, next_state;
    logic       ps_n, ps_z, ps_c;
    logic       flag_ld, flag_clr;
    logic       push, pop, rs_full, rs_empty;
    logic       mem_rdy;

    assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    cu_ret_stack #(.PC_W(PC_W), .RS_DEPTH(RS_DEPTH)) u_rs (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_in),
        .top   (ret_pc),
        .full  (rs_full),
        .empty (rs_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_RESET;
        else       state <= next_state;
    end

    // Flag register
    always_ff @(posedge clk) begin
        if (reset || flag_clr) {ps_n, ps_z, ps_c} <= 3'b000;
        else if (flag_ld)      {ps_n, ps_z, ps_c} <= {N, Z, C};
    end

    // Next state and control word
    always_comb begin
        next_state = state;
        W_Adr   = 3'b000;
        R_Adr   = 3'b000;
        S_Adr   = 3'b000;
        adr_sel = 1'b0;
        s_sel   = 1'b0;
        pc_inc  = 1'b0;
        ir_ld   = 1'b0;
        mw_en   = 1'b0;
        rw_en   = 1'b0;
        pc_ld   = 1'b0;
        pc_sel  = PCSEL_ALU;
        alu_op  = ALU_ADD;
        mem_req = 1'b0;
        flag_ld  = 1'b0;
        flag_clr = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        case (state)
            S_RESET:  next_state = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_rdy) begin
                    ir_ld = 1'b1; pc_inc = 1'b1; next_state = S_DECODE;
                end
            end
            S_DECODE: next_state = decode_op(IR[15:9]);
            S_ADD, S_SUB: begin
                W_Adr = IR[8:6]; R_Adr = IR[5:3]; S_Adr = IR[2:0];
                alu_op = (state == S_ADD) ? ALU_ADD : ALU_SUB;
                rw_en = 1'b1; flag_ld = 1'b1; next_state = S_FETCH;
            end
            S_CMP: begin
                R_Adr = IR[5:3]; S_Adr = IR[2:0];
                alu_op = ALU_SUB; flag_ld = 1'b1; next_state = S_FETCH;
            end
            S_MOV: begin
                W_Adr = IR[8:6]; R_Adr = IR[5:3];
                alu_op = ALU_PASS; rw_en = 1'b1; next_state = S_FETCH;
            end
            S_SHL, S_SHR, S_INC, S_DEC: begin
                W_Adr = IR[8:6]; R_Adr = IR[5:3];
                case (state)
                    S_SHL:   alu_op = ALU_SHL;
                    S_SHR:   alu_op = ALU_SHR;
                    S_INC:   alu_op = ALU_INC;
                    default: alu_op = ALU_DEC;
                endcase
                rw_en = 1'b1; flag_ld = 1'b1; next_state = S_FETCH;
            end
            S_LD: begin
                W_Adr = IR[8:6]; R_Adr = IR[5:3];
                adr_sel = 1'b1; s_sel = 1'b1; mem_req = 1'b1;
                if (mem_rdy) begin
                    rw_en = 1'b1; next_state = S_FETCH;
                end
            end
            S_STO: begin
                R_Adr = IR[5:3]; S_Adr = IR[2:0];
                adr_sel = 1'b1; mem_req = 1'b1;
                if (mem_rdy) begin
                    mw_en = 1'b1; next_state = S_FETCH;
                end
            end
            S_LDI: begin
                W_Adr = IR[8:6]; s_sel = 1'b1; mem_req = 1'b1;
                if (mem_rdy) begin
                    rw_en = 1'b1; pc_inc = 1'b1; flag_ld = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_JE:  begin pc_ld = ps_z;  next_state = S_FETCH; end
            S_JNE: begin pc_ld = ~ps_z; next_state = S_FETCH; end
            S_JC:  begin pc_ld = ps_c;  next_state = S_FETCH; end
            S_JN:  begin pc_ld = ps_n;  next_state = S_FETCH; end
            S_JMP: begin
                R_Adr = IR[5:3]; alu_op = ALU_PASS;
                pc_ld = 1'b1; flag_ld = 1'b1; next_state = S_FETCH;
            end
            S_CALL: begin
                R_Adr = IR[5:3]; alu_op = ALU_PASS;
                if (rs_full) next_state = S_STACK_FAULT;
                else begin
                    push = 1'b1; pc_ld = 1'b1; next_state = S_FETCH;
                end
            end
            S_RET: begin
                if (rs_empty) next_state = S_STACK_FAULT;
                else begin
                    pop = 1'b1; pc_ld = 1'b1; pc_sel = PCSEL_RET;
                    next_state = S_FETCH;
                end
            end
            S_HALT, S_ILLEGAL_OP, S_STACK_FAULT: flag_clr = 1'b1;
            default: next_state = S_RESET;
        endcase
    end

    // Status: fixed codes for housekeeping/trap states, else {flags, state}
    always_comb begin
        case (state)
            S_RESET:       status = STAT_RESET;
            S_FETCH:       status = STAT_FETCH;
            S_DECODE:      status = STAT_DECODE;
            S_ILLEGAL_OP:  status = STAT_ILL;
            S_STACK_FAULT: status = STAT_SFAULT;
            default:       status = {ps_n, ps_z, ps_c, state};
        endcase
    end

endmodule

// File: tb/tb_cu_gen2.sv
// Directed scoreboard bench for cu_gen2.
module tb_cu_gen2;

    logic        clk, reset;
    logic [15:0] IR;
    logic        N, Z, C, mem_ready;
    logic [15:0] pc_in;
    logic [2:0]  W_Adr, R_Adr, S_Adr;
    logic        adr_sel, s_sel, pc_inc, ir_ld, mw_en, rw_en, pc_ld, mem_req;
    logic [1:0]  pc_sel;
    logic [3:0]  alu_op;
    logic [15:0] ret_pc;
    logic [7:0]  status;

    cu_gen2 dut (
        .clk(clk), .reset(reset), .IR(IR), .N(N), .Z(Z), .C(C),
        .mem_ready(mem_ready), .pc_in(pc_in),
        .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
        .adr_sel(adr_sel), .s_sel(s_sel), .pc_inc(pc_inc), .ir_ld(ir_ld),
        .mw_en(mw_en), .rw_en(rw_en), .pc_ld(pc_ld), .pc_sel(pc_sel),
        .alu_op(alu_op), .mem_req(mem_req), .ret_pc(ret_pc), .status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int F_STATUS = 0, F_RW = 1, F_IRLD = 2, F_PCINC = 3,
                   F_MEMREQ = 4, F_PCLD = 5, F_PCSEL = 6, F_RETPC = 7,
                   F_WADR = 8;

    typedef struct {
        string       tag;
        int          fld;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] observe(input int f);
        case (f)
            F_STATUS: return 32'(status);
            F_RW:     return 32'(rw_en);
            F_IRLD:   return 32'(ir_ld);
            F_PCINC:  return 32'(pc_inc);
            F_MEMREQ: return 32'(mem_req);
            F_PCLD:   return 32'(pc_ld);
            F_PCSEL:  return 32'(pc_sel);
            F_RETPC:  return 32'(ret_pc);
            F_WADR:   return 32'(W_Adr);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic void push_exp(input string tag, input int f, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.fld = f; e.val = v;
        sb.push_back(e);
    endfunction

    // status for an execute state: {N,Z,C,state}
    function automatic logic [31:0] st(input logic [2:0] fl, input logic [4:0] s);
        return 32'({fl, s});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check();
        exp_t e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.fld);
            n_assert++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        reset = 1'b1; IR = 16'h0000; N = 0; Z = 0; C = 0;
        mem_ready = 1'b1; pc_in = 16'h0000;
        step();
        reset = 1'b0;

        // Reset -> FETCH -> DECODE -> ADD
        push_exp("reset_status", F_STATUS, 32'hFF);
        push_exp("reset_rw", F_RW, 0);
        push_exp("reset_irld", F_IRLD, 0);
        push_exp("reset_memreq", F_MEMREQ, 0);
        push_exp("reset_retpc", F_RETPC, 0);
        check(); step();
        IR = 16'hE000;
        push_exp("fetch_status", F_STATUS, 32'h80);
        push_exp("fetch_memreq", F_MEMREQ, 1);
        push_exp("fetch_irld", F_IRLD, 1);
        check(); step();
        push_exp("decode_status", F_STATUS, 32'hC0);
        check(); step();
        push_exp("add_rw", F_RW, 1);
        push_exp("add_status", F_STATUS, st(3'b000, 5'd3));
        check(); step();

        // FETCH wait states
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_exp("wait_memreq", F_MEMREQ, 1);
            push_exp("wait_irld", F_IRLD, 0);
            push_exp("wait_pcinc", F_PCINC, 0);
            push_exp("wait_status", F_STATUS, 32'h80);
            check(); step();
        end
        mem_ready = 1'b1; IR = 16'hC000; pc_in = 16'h0123;
        push_exp("rdy_irld", F_IRLD, 1);
        push_exp("rdy_pcinc", F_PCINC, 1);
        check(); step();

        // CALL then RET
        step();
        push_exp("call_pcld", F_PCLD, 1);
        push_exp("call_pcsel", F_PCSEL, 0);
        push_exp("call_status", F_STATUS, st(3'b000, 5'd19));
        check(); step();
        IR = 16'hC200;
        push_exp("after_call_retpc", F_RETPC, 32'h0123);
        check(); step();
        step();
        push_exp("ret_pcld", F_PCLD, 1);
        push_exp("ret_pcsel", F_PCSEL, 2);
        push_exp("ret_retpc", F_RETPC, 32'h0123);
        push_exp("ret_status", F_STATUS, st(3'b000, 5'd20));
        check(); step();
        IR = 16'hE240;
        push_exp("after_ret_retpc", F_RETPC, 0);
        check(); step();
        step();

        // SUB sets N, JN taken
        N = 1'b1;
        push_exp("sub_status", F_STATUS, st(3'b000, 5'd4));
        push_exp("sub_wadr", F_WADR, 1);
        push_exp("sub_rw", F_RW, 1);
        check(); step();
        N = 1'b0; IR = 16'hC400;
        step(); step();
        push_exp("jn_taken_pcld", F_PCLD, 1);
        push_exp("jn_taken_status", F_STATUS, st(3'b100, 5'd21));
        check(); step();

        // CMP clears N, sets Z; JN not taken, JE taken
        IR = 16'hE400;
        step(); step();
        Z = 1'b1;
        push_exp("cmp_rw", F_RW, 0);
        push_exp("cmp_status", F_STATUS, st(3'b100, 5'd5));
        check(); step();
        Z = 1'b0; IR = 16'hC400;
        step(); step();
        push_exp("jn_not_pcld", F_PCLD, 0);
        push_exp("jn_not_status", F_STATUS, st(3'b010, 5'd21));
        check(); step();
        IR = 16'hF800;
        step(); step();
        push_exp("je_pcld", F_PCLD, 1);
        push_exp("je_status", F_STATUS, st(3'b010, 5'd15));
        check(); step();

        // RS_DEPTH+1 CALLs -> STACK_FAULT
        for (int i = 0; i < 5; i++) begin
            IR = 16'hC000; pc_in = 16'(16'h0100 + i);
            step(); step();
            if (i < 4) push_exp("call_n_pcld", F_PCLD, 1);
            else begin
                push_exp("call_full_pcld", F_PCLD, 0);
                push_exp("call_full_retpc", F_RETPC, 32'h0103);
            end
            check(); step();
        end
        for (int i = 0; i < 3; i++) begin
            push_exp("sfault_status", F_STATUS, 32'hE0);
            push_exp("sfault_pcld", F_PCLD, 0);
            check(); step();
        end

        // Reset during LD wait clears state and stack
        reset = 1'b1; step(); reset = 1'b0;
        push_exp("reset2_status", F_STATUS, 32'hFF);
        check(); step();
        IR = 16'hC000; pc_in = 16'h0456;
        step(); step(); step();
        IR = 16'hF000;
        step(); step();
        mem_ready = 1'b0;
        push_exp("ld_wait_memreq", F_MEMREQ, 1);
        push_exp("ld_wait_rw", F_RW, 0);
        push_exp("ld_wait_retpc", F_RETPC, 32'h0456);
        push_exp("ld_wait_status", F_STATUS, st(3'b000, 5'd11));
        check();
        reset = 1'b1; step(); reset = 1'b0; mem_ready = 1'b1;
        push_exp("ld_reset_status", F_STATUS, 32'hFF);
        push_exp("ld_reset_rw", F_RW, 0);
        push_exp("ld_reset_retpc", F_RETPC, 0);
        check(); step();
        IR = 16'hC200;
        step(); step();
        push_exp("ret_empty_pcld", F_PCLD, 0);
        check(); step();
        push_exp("ret_empty_status", F_STATUS, 32'hE0);
        check();

        // Illegal opcode traps and holds
        reset = 1'b1; step(); reset = 1'b0;
        IR = 16'h0000;
        step(); step(); step();
        push_exp("illegal_status", F_STATUS, 32'hF0);
        check(); step();
        push_exp("illegal_hold", F_STATUS, 32'hF0);
        check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
